// File: rtl/sram_cycle_controller_if.sv
// sram_cycle_controller_if: ISA-side strobes and SRAM pins of the SRAM cycle controller.
interface sram_cycle_controller_if;
  logic [19:0] address;
  logic [7:0]  data_bus_in;
  logic        memory_read_n;
  logic        memory_write_n;
  logic        io_read_n;
  logic        io_write_n;
  logic        address_enable_n;
  logic        ram_select_n;
  logic        ems_enabled;
  logic [1:0]  ems_address;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        io_channel_ready;
  logic [20:0] sram_addr;
  logic [7:0]  sram_data_o;
  logic        sram_data_oe;
  logic [7:0]  sram_data_i;
  logic        sram_we_n;
  logic        sram_oe_n;
  modport master (
    output address, data_bus_in, memory_read_n, memory_write_n, io_read_n, io_write_n,
           address_enable_n, ram_select_n, ems_enabled, ems_address, sram_data_i,
    input  data_out, data_out_valid, io_channel_ready, sram_addr, sram_data_o,
           sram_data_oe, sram_we_n, sram_oe_n
  );
  modport slave (
    input  address, data_bus_in, memory_read_n, memory_write_n, io_read_n, io_write_n,
           address_enable_n, ram_select_n, ems_enabled, ems_address, sram_data_i,
    output data_out, data_out_valid, io_channel_ready, sram_addr, sram_data_o,
           sram_data_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_cycle_controller.sv
// sram_cycle_controller: times chipset RAM cycles onto async SRAM, stretching READY until done.
// Optional EMS page mapping into the upper SRAM half is built with `define EMS_PAGE_EN.
module sram_cycle_controller #(
  parameter int         WAIT_CYCLES = 2,
  parameter logic [9:0] EMS_IO_BASE = 10'h260
) (
  input logic clock,
  input logic reset,
  sram_cycle_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        wr, wr_nx;
  logic [7:0]  read_data;
  logic        strobe, start, ems_map, ems_block, io_hit_rd;
  logic [20:0] mapped;
  logic [7:0]  io_rd_data;

`ifdef EMS_PAGE_EN
  logic [7:0]  ems [4];
  logic        io_write_q;
  logic        io_hit;
  logic [9:0]  io_off;
  logic [19:0] win_base;
  logic        in_win;
  logic [7:0]  page;
  logic        unused;
  assign unused = page[6];
  always_comb begin
    io_off     = bus.address[9:0] - EMS_IO_BASE;
    io_hit     = bus.address_enable_n && io_off < 10'd4;
    io_hit_rd  = io_hit && !bus.io_read_n;
    io_rd_data = ems[io_off[1:0]];
    win_base   = bus.ems_address == 2'b00 ? 20'hC0000 :
                 bus.ems_address == 2'b01 ? 20'hD0000 :
                 bus.ems_address == 2'b10 ? 20'hE0000 : 20'hC8000;
    in_win     = bus.ems_enabled && bus.address >= win_base && (bus.address - win_base) < 20'h10000;
    page       = ems[bus.address[15:14]];
    ems_map    = in_win && page[7];
    ems_block  = in_win && !page[7];
    mapped     = ems_map ? {1'b1, page[5:0], bus.address[13:0]} : {1'b0, bus.address};
  end
  // Registers load only on the falling edge of io_write_n, so a long I/O write stores once.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      io_write_q <= 1'b1;
      ems        <= '{default: 8'h00};
    end else begin
      io_write_q <= bus.io_write_n;
      if (io_hit && !bus.io_write_n && io_write_q) ems[io_off[1:0]] <= bus.data_bus_in;
    end
`else
  logic unused;
  assign unused = ^{bus.io_read_n, bus.io_write_n, bus.address_enable_n, bus.ems_enabled,
                    bus.ems_address, EMS_IO_BASE};
  always_comb begin
    io_hit_rd  = 1'b0;
    io_rd_data = 8'h00;
    ems_map    = 1'b0;
    ems_block  = 1'b0;
    mapped     = {1'b0, bus.address};
  end
`endif

  // Reset gates start so READY is released at once even with strobes still low.
  always_comb begin
    strobe   = !bus.memory_read_n || !bus.memory_write_n;
    start    = !reset && strobe && !ems_block && (ems_map || !bus.ram_select_n);
    state_nx = state == IDLE   ? (start ? SETUP : IDLE) :
               state == SETUP  ? ACCESS :
               state == ACCESS ? (cnt == 4'd0 ? DONE : ACCESS) :
                                 (strobe ? DONE : IDLE);
    cnt_nx   = state == SETUP ? 4'(WAIT_CYCLES - 1) : state == ACCESS ? cnt - 4'd1 : cnt;
    wr_nx    = state == IDLE && start ? !bus.memory_write_n : wr;
    bus.io_channel_ready = !((state == IDLE && start) || state == SETUP || state == ACCESS);
    bus.data_out_valid   = io_hit_rd || (state == DONE && !wr && !bus.memory_read_n);
    bus.data_out         = io_hit_rd ? io_rd_data : read_data;
  end

  // SRAM strobes are registered from next-state so they never glitch on state decode.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      wr               <= 1'b0;
      read_data        <= 8'h00;
      bus.sram_addr    <= 21'h0;
      bus.sram_data_o  <= 8'h00;
      bus.sram_data_oe <= 1'b0;
      bus.sram_we_n    <= 1'b1;
      bus.sram_oe_n    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wr    <= wr_nx;
      if (state == IDLE && start) begin
        bus.sram_addr <= mapped;
        if (!bus.memory_write_n) bus.sram_data_o <= bus.data_bus_in;
      end
      if (state == ACCESS && cnt == 4'd0 && !wr) read_data <= bus.sram_data_i;
      bus.sram_we_n    <= !(state_nx == ACCESS && wr_nx);
      bus.sram_oe_n    <= !(!wr_nx && (state_nx == SETUP || state_nx == ACCESS));
      bus.sram_data_oe <= (wr_nx && (state_nx == SETUP || state_nx == ACCESS)) ||
                          (state == ACCESS && wr && state_nx == DONE);
    end
endmodule
